// File: rtl/vga_line_fetch.sv
// VGA pixel fetch: ping-pong line buffers filled from a 320x240 RGB332
// framebuffer, scanned out with 2x2 replication and aligned sync/blank.
module vga_line_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int FB_W     = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hcount,
  input  logic [15:0] vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        underflow
);

  localparam int CW = $clog2(FB_W);
  localparam logic [15:0] LP_HACT  = 16'(H_ACTIVE);
  localparam logic [15:0] LP_VACT  = 16'(V_ACTIVE);
  localparam logic [15:0] LP_VLAST = 16'(V_TOTAL - 1);
  localparam logic [16:0] LP_FBW   = 17'(FB_W);
  localparam logic [CW-1:0] LP_CLAST = CW'(FB_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [16:0]   r_addr;
  logic [16:0]   r_base;
  logic [CW-1:0] r_col;
  logic          r_und;
  logic          r_sel;
  logic          r_fv;

  logic [7:0]    r_lb [2][FB_W];

  logic [7:0]    r_pix;
  logic          r_bl1;
  logic          r_fv1;
  logic          r_hs1;
  logic          r_vs1;
  logic [7:0]    r_red;
  logic [7:0]    r_grn;
  logic [7:0]    r_blu;
  logic          r_hs2;
  logic          r_vs2;
  logic          r_bl2;

  logic [15:0]   w_vnext;
  logic          w_start;
  logic          w_swap;
  logic [16:0]   w_base_nxt;
  logic          w_wr;
  logic          w_in_act;
  logic [CW-1:0] w_col;
  logic          w_rd_sel;
  logic          w_fv;
  logic          w_show;

  assign w_vnext = (vcount == LP_VLAST) ? 16'd0 : vcount + 16'd1;
  assign w_start = (hcount == 16'd0) && !w_vnext[0] && (w_vnext < LP_VACT);
  assign w_swap  = (hcount == 16'd0) && !vcount[0] && (vcount < LP_VACT);

  // Row base tracked incrementally; the row-0 fetch re-anchors it.
  assign w_base_nxt = (w_vnext == 16'd0) ? 17'd0 : r_base + LP_FBW;

  assign w_wr = !rst && (r_state == S_WAIT) && mem_rvalid && !w_swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_base  <= '0;
      r_col   <= '0;
      r_und   <= 1'b0;
      r_sel   <= 1'b0;
      r_fv    <= 1'b0;
    end else begin
      if (w_swap) begin
        r_sel <= ~r_sel;
        r_fv  <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_col   <= '0;
            r_base  <= w_base_nxt;
            r_addr  <= w_base_nxt;
          end
        end
        S_REQ: begin
          if (w_swap) begin
            r_und   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= mem_gnt ? S_DRAIN : S_IDLE;
          end else if (mem_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_swap) begin
            r_und   <= 1'b1;
            r_state <= mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (mem_rvalid) begin
            if (r_col == LP_CLAST) begin
              r_state <= S_IDLE;
            end else begin
              r_col   <= r_col + 1'b1;
              r_addr  <= r_addr + 17'd1;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_lb[~r_sel][r_col] <= mem_rdata;
  end

  // On a swap cycle the scan already reads the newly promoted buffer.
  assign w_in_act = hcount < LP_HACT;
  assign w_col    = hcount[CW:1];
  assign w_rd_sel = w_swap ? ~r_sel : r_sel;
  assign w_fv     = r_fv | w_swap;
  assign w_show   = r_bl1 & r_fv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix <= '0;
      r_bl1 <= 1'b0;
      r_fv1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_bl2 <= 1'b0;
    end else begin
      r_pix <= w_in_act ? r_lb[w_rd_sel][w_col] : 8'h00;
      r_bl1 <= blank_in;
      r_fv1 <= w_fv;
      r_hs1 <= hsync_in;
      r_vs1 <= vsync_in;
      r_red <= w_show ? {r_pix[7:5], r_pix[7:5], r_pix[7:6]} : 8'h00;
      r_grn <= w_show ? {r_pix[4:2], r_pix[4:2], r_pix[4:3]} : 8'h00;
      r_blu <= w_show ? {4{r_pix[1:0]}} : 8'h00;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_bl2 <= r_bl1;
    end
  end

  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign underflow = r_und;
  assign Red       = r_red;
  assign Green     = r_grn;
  assign Blue      = r_blu;
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;
  assign blank_out = r_bl2;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: memory model, line-buffer reference model and
// per-cycle comparison, plus fixed expectations for key scenarios.
module tb_vga_line_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hcount;
  logic [15:0] vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;
  logic        underflow;

  always #5 clk = ~clk;

  vga_line_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .blank_in  (blank_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .Red       (Red),
    .Green     (Green),
    .Blue      (Blue),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out),
    .underflow (underflow)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
    int         gen;
    int         col;
  } rsp_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    bit         hs;
    bit         vs;
    bit         bl;
    bit         known;
  } pix_t;

  localparam pix_t PIX_RST = '{8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1};

  int n_chk = 0;
  int n_fail = 0;
  int cycn = 0;
  int lat = 1;
  int gmode = 0;
  bit waited = 0;

  rsp_t pend[$];
  rsp_t cur;
  bit   cur_v;

  // reference state: what the display and fetch must look like
  bit         m_sel = 0;
  bit         m_fv = 0;
  bit         m_und = 0;
  bit         m_act = 0;
  bit         m_req = 0;
  int         m_row = 0;
  int         m_col = 0;
  int         m_gen = 0;
  logic [7:0] mbuf [2][320];
  bit         mknown [2][320];
  pix_t       d1 = PIX_RST;
  pix_t       q = PIX_RST;

  int g_cnt = 0;
  int g_first = -1;
  int g_last = -1;
  bit lit_arm = 0;
  int lit_cd = 0;
  bit track0 = 0;
  int nz = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cycn);
    end
  endtask

  function automatic logic [7:0] x3(input int c);
    return 8'(c * 36 + c / 2);
  endfunction

  task automatic model_step(input int h, input int v, input bit r);
    int n;
    bit st;
    bit sw;
    bit sp;
    pix_t p;
    logic [7:0] px;
    if (mem_req && mem_gnt) begin
      pend.push_back('{cycn + lat, mem_addr[7:0], m_gen, m_col});
      if (g_cnt == 0) g_first = int'(mem_addr);
      g_last = int'(mem_addr);
      g_cnt++;
    end
    if (r) begin
      m_gen++;
      m_act = 0;
      m_req = 0;
      m_sel = 0;
      m_fv = 0;
      m_und = 0;
      d1 = PIX_RST;
      q = PIX_RST;
      return;
    end
    n = (v + 1) % 525;
    st = (h == 0) && (n % 2 == 0) && (n < 480);
    sw = (h == 0) && (v % 2 == 0) && (v < 480);
    sp = sw ? !m_sel : m_sel;
    p = '{8'd0, 8'd0, 8'd0, hsync_in, vsync_in, blank_in, 1'b1};
    if (blank_in && (m_fv || sw) && h < 640) begin
      px = mbuf[sp][h / 2];
      p.known = mknown[sp][h / 2];
      p.r = x3(int'(px[7:5]));
      p.g = x3(int'(px[4:2]));
      p.b = 8'(int'(px[1:0]) * 85);
    end
    q = d1;
    d1 = p;
    if (sw) begin
      if (m_act) begin
        m_und = 1;
        m_act = 0;
        m_req = 0;
        m_gen++;
      end
      m_sel = !m_sel;
      m_fv = 1;
    end
    if (mem_req && mem_gnt) m_req = 0;
    if (cur_v && cur.gen == m_gen && m_act) begin
      mbuf[!m_sel][cur.col] = 8'((m_row * 320 + cur.col) & 255);
      mknown[!m_sel][cur.col] = 1;
      m_col = cur.col + 1;
      if (m_col == 320) begin
        m_act = 0;
        m_req = 0;
      end else begin
        m_req = 1;
      end
    end
    if (st && !m_act) begin
      m_act = 1;
      m_gen++;
      m_row = n / 2;
      m_col = 0;
      m_req = 1;
    end
  endtask

  task automatic check();
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    if (m_req) chk("mem_addr", {15'd0, mem_addr}, m_row * 320 + m_col);
    chk("underflow", {31'd0, underflow}, {31'd0, m_und});
    chk("sync_blank", {29'd0, hsync_out, vsync_out, blank_out},
        {29'd0, q.hs, q.vs, q.bl});
    if (q.known) chk("rgb", {8'd0, Red, Green, Blue},
                     {8'd0, q.r, q.g, q.b});
    if (track0 && {Red, Green, Blue} != 24'd0) nz++;
    if (lit_cd > 0) begin
      lit_cd--;
      if (lit_cd == 0) begin
        chk("pix_red", {24'd0, Red}, 32'h92);
        chk("pix_green", {24'd0, Green}, 32'h24);
        chk("pix_blue", {24'd0, Blue}, 32'h55);
        chk("pix_blank", {31'd0, blank_out}, 32'd1);
      end
    end
  endtask

  task automatic drive(input int h, input int v, input bit r);
    @(negedge clk);
    rst = r;
    hcount = 16'(h);
    vcount = 16'(v);
    blank_in = (h < 640) && (v < 480);
    hsync_in = !(h >= 656 && h < 752);
    vsync_in = !(v == 490 || v == 491);
    if (gmode == 0) mem_gnt = 1'b1;
    else mem_gnt = waited || ($urandom_range(3) != 0);
    waited = mem_req && !mem_gnt;
    cur_v = 0;
    if (pend.size() > 0 && pend[0].due == cycn) begin
      cur = pend.pop_front();
      cur_v = 1;
    end
    mem_rvalid = cur_v;
    mem_rdata = cur_v ? cur.data : 8'($urandom);
    if (lit_arm && h == 10 && v == 4) lit_cd = 2;
    model_step(h, v, r);
    @(posedge clk);
    #1;
    check();
    cycn++;
  endtask

  task automatic run_line(input int v);
    for (int h = 0; h < 800; h++) drive(h, v, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++)
      drive(int'($urandom_range(799)), int'($urandom_range(524)), 1'b1);
  endtask

  initial begin
    int h;
    bit hit;
    rst = 1'b1;
    hcount = '0;
    vcount = '0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    blank_in = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 320; c++) mknown[b][c] = 0;

    do_reset();
    chk("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    chk("rst_sync", {29'd0, hsync_out, vsync_out, blank_out}, 32'd6);
    chk("rst_mem", {14'd0, mem_req, mem_addr}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);

    // prefetch of row 0 and first frame lines, 1-cycle memory
    lat = 1;
    gmode = 0;
    track0 = 1;
    run_line(522);
    run_line(523);
    g_cnt = 0;
    drive(0, 524, 1'b0);
    chk("prefetch_req", {14'd0, mem_req, mem_addr}, 32'h20000);
    for (int x = 1; x < 800; x++) drive(x, 524, 1'b0);
    chk("prefetch_grants", g_cnt, 320);
    chk("prefetch_last", g_last, 319);
    chk("prefetch_idle", {31'd0, mem_req}, 32'd0);
    track0 = 0;
    chk("dark_before_swap", nz, 0);
    lit_arm = 1;
    for (int v = 0; v < 6; v++) run_line(v);
    lit_arm = 0;

    // randomly delayed grants
    gmode = 1;
    for (int v = 6; v < 10; v++) run_line(v);
    chk("bp_underflow", {31'd0, underflow}, 32'd0);

    // short lines walk the row accumulator to the bottom of the frame
    gmode = 0;
    for (int x = 0; x < 4; x++) drive(x, 10, 1'b0);
    for (int l = 11; l <= 473; l += 2) begin
      drive(0, l, 1'b0);
      for (int x = 0; x < 4; x++) drive(x, l + 1, 1'b0);
    end
    run_line(475);
    run_line(476);
    g_cnt = 0;
    run_line(477);
    chk("row239_first", g_first, 239 * 320);
    chk("row239_last", g_last, 239 * 320 + 319);
    for (int v = 478; v < 481; v++) run_line(v);

    // slow memory forces an incomplete fetch at swap
    lat = 4;
    do_reset();
    run_line(524);
    drive(0, 0, 1'b0);
    chk("uf_set", {31'd0, underflow}, 32'd1);
    for (int x = 1; x < 800; x++) drive(x, 0, 1'b0);
    run_line(1);
    run_line(2);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);

    // reset while a request is outstanding
    lat = 3;
    do_reset();
    hit = 0;
    h = 0;
    while (h < 800) begin
      drive(h, 524, 1'b0);
      h++;
      if (!hit && m_act && m_col == 100 && pend.size() != 0 && h < 800) begin
        hit = 1;
        drive(h, 524, 1'b1);
        h++;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        lat = 1;
      end
    end
    chk("rst_mid_hit", {31'd0, hit}, 32'd1);
    run_line(0);
    chk("rst_mid_no_uf", {31'd0, underflow}, 32'd0);
    g_cnt = 0;
    run_line(1);
    chk("rst_restart_base", g_first, 320);
    chk("rst_restart_cnt", g_cnt, 320);
    run_line(2);
    run_line(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
